// File: rtl/postfix_evaluator.sv
// ---------------------------------------------------------------------------
// postfix_evaluator
//
// Purpose:
//   This is the stage after the infix-to-postfix arranger. When the arranger
//   signals finish, this block reads the postfix BRAM from address 1 up to
//   the arranger's top address. It evaluates the tokens with an internal
//   operand stack. It then reports either a 32-bit signed result or an error
//   code to the calculator display/control logic.
//
// Token format (36 bits):
//   [32] = 0 : operand, value in [31:0] (two's complement)
//   [32] = 1 : operator, code in [8:0]
//   [35:33]  : ignored
//
// Ports:
//   CLK_1MHz      in   1   system clock, rising edge
//   RSTN          in   1   asynchronous active-low reset
//   start         in   1   begin evaluation (arranger finish); sampled in IDLE only
//   top_addr_posf in   9   last valid postfix address, latched on accepted start
//   addr_posf_b   out  9   postfix BRAM read address (registered)
//   do_posf_b     in  36   postfix BRAM read data, valid one cycle after address
//   result        out 32   signed result, held until the next evaluation ends
//   done          out  1   one-cycle pulse at the end of evaluation
//   busy          out  1   high from accepted start until done
//   err           out  1   error flag, held with result
//   err_code      out  3   0 none, 1 DIV0, 2 UNDERFLOW, 3 OVERFLOW,
//                          4 BAD_OP, 5 LEFTOVER
// ---------------------------------------------------------------------------
module postfix_evaluator #(
    parameter int         STACK_DEPTH = 16,
    parameter int         LOG_STACK   = 4,
    parameter logic [8:0] OP_ADD      = 9'h020,
    parameter logic [8:0] OP_SUB      = 9'h021,
    parameter logic [8:0] OP_MUL      = 9'h040,
    parameter logic [8:0] OP_DIV      = 9'h041
) (
    input  logic        CLK_1MHz,
    input  logic        RSTN,
    input  logic        start,
    input  logic [8:0]  top_addr_posf,
    output logic [8:0]  addr_posf_b,
    input  logic [35:0] do_posf_b,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic [2:0]  err_code
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        EX,
        FIN,
        DONE
    } state_t;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_DIV0      = 3'd1;
    localparam logic [2:0] ERR_UNDERFLOW = 3'd2;
    localparam logic [2:0] ERR_OVERFLOW  = 3'd3;
    localparam logic [2:0] ERR_BAD_OP    = 3'd4;
    localparam logic [2:0] ERR_LEFTOVER  = 3'd5;

    localparam logic [LOG_STACK:0] SP_ONE  = (LOG_STACK+1)'(1);
    localparam logic [LOG_STACK:0] SP_TWO  = (LOG_STACK+1)'(2);
    localparam logic [LOG_STACK:0] SP_FULL = (LOG_STACK+1)'(STACK_DEPTH);

    state_t                 state;
    logic [8:0]             top_q;
    logic [LOG_STACK:0]     sp;
    logic signed [31:0]     stack [STACK_DEPTH];

    // Token decode
    logic                   is_op;
    logic signed [31:0]     tok_val;
    logic [8:0]             op_code;
    logic                   unused_tok_bits;

    // Stack addressing and operands
    logic [LOG_STACK:0]     sp_m1;
    logic [LOG_STACK:0]     sp_m2;
    logic [LOG_STACK-1:0]   top_idx;
    logic [LOG_STACK-1:0]   nxt_idx;
    logic signed [31:0]     opnd_a;
    logic signed [31:0]     opnd_b;

    // ALU
    logic signed [31:0]     div_den;
    logic signed [31:0]     div_q;
    logic signed [31:0]     alu_out;
    logic                   op_known;

    // Execute-stage checks and stack write port
    logic [2:0]             ex_code;
    logic                   stk_we;
    logic [LOG_STACK-1:0]   stk_widx;
    logic signed [31:0]     stk_wdata;

    assign is_op   = do_posf_b[32];
    assign tok_val = do_posf_b[31:0];
    assign op_code = do_posf_b[8:0];

    // The top three token bits have no meaning for the evaluator.
    assign unused_tok_bits = ^do_posf_b[35:33];

    // b is the top of the stack and a is the entry just below it. These
    // indices are only meaningful when sp >= 2. The execute checks stop any
    // use of them when the stack is shallower.
    always_comb begin
        sp_m1   = sp - SP_ONE;
        sp_m2   = sp - SP_TWO;
        top_idx = sp_m1[LOG_STACK-1:0];
        nxt_idx = sp_m2[LOG_STACK-1:0];
        opnd_a  = stack[nxt_idx];
        opnd_b  = stack[top_idx];
    end

    // The divider never sees 0 or -1. A zero divisor is reported as an error.
    // For a divisor of -1, negation gives the same answer and wraps
    // -2^31 / -1 back to -2^31 without a divide overflow.
    always_comb begin
        op_known = (op_code == OP_ADD) || (op_code == OP_SUB) ||
                   (op_code == OP_MUL) || (op_code == OP_DIV);
        div_den  = ((opnd_b == 32'sd0) || (opnd_b == -32'sd1)) ? 32'sd1 : opnd_b;
        div_q    = opnd_a / div_den;
        alu_out  = 32'sd0;
        if (op_code == OP_ADD) begin
            alu_out = opnd_a + opnd_b;
        end else if (op_code == OP_SUB) begin
            alu_out = opnd_a - opnd_b;
        end else if (op_code == OP_MUL) begin
            alu_out = opnd_a * opnd_b;
        end else if (op_code == OP_DIV) begin
            alu_out = (opnd_b == -32'sd1) ? -opnd_a : div_q;
        end
    end

    // Operator errors are checked in this order: too few operands first,
    // then an unknown code, then division by zero.
    always_comb begin
        ex_code = ERR_NONE;
        if (!is_op) begin
            if (sp == SP_FULL) begin
                ex_code = ERR_OVERFLOW;
            end
        end else if (sp < SP_TWO) begin
            ex_code = ERR_UNDERFLOW;
        end else if (!op_known) begin
            ex_code = ERR_BAD_OP;
        end else if ((op_code == OP_DIV) && (opnd_b == 32'sd0)) begin
            ex_code = ERR_DIV0;
        end
    end

    // An operand is pushed at sp. An operator result replaces a, at sp-2.
    always_comb begin
        stk_we    = 1'b0;
        stk_widx  = sp[LOG_STACK-1:0];
        stk_wdata = tok_val;
        if ((state == EX) && (ex_code == ERR_NONE)) begin
            stk_we = 1'b1;
            if (is_op) begin
                stk_widx  = nxt_idx;
                stk_wdata = alu_out;
            end
        end
    end

    // Stack contents are never reset. Only entries below sp are read.
    always_ff @(posedge CLK_1MHz) begin
        if (stk_we) begin
            stack[stk_widx] <= stk_wdata;
        end
    end

    always_ff @(posedge CLK_1MHz or negedge RSTN) begin
        if (!RSTN) begin
            state       <= IDLE;
            top_q       <= 9'd0;
            sp          <= '0;
            addr_posf_b <= 9'd0;
            result      <= 32'd0;
            done        <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        top_q       <= top_addr_posf;
                        addr_posf_b <= 9'd1;
                        sp          <= '0;
                        busy        <= 1'b1;
                        err         <= 1'b0;
                        err_code    <= ERR_NONE;
                        // An empty program goes straight to the final check,
                        // and that check reports LEFTOVER.
                        state       <= (top_addr_posf == 9'd0) ? FIN : RD;
                    end
                end
                RD: begin
                    state <= EX;
                end
                EX: begin
                    if (ex_code != ERR_NONE) begin
                        result   <= 32'd0;
                        err      <= 1'b1;
                        err_code <= ex_code;
                        state    <= DONE;
                    end else begin
                        sp <= is_op ? sp_m1 : (sp + SP_ONE);
                        if (addr_posf_b == top_q) begin
                            state <= FIN;
                        end else begin
                            addr_posf_b <= addr_posf_b + 9'd1;
                            state       <= RD;
                        end
                    end
                end
                FIN: begin
                    if (sp == SP_ONE) begin
                        result   <= stack[0];
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                    end else begin
                        result   <= 32'd0;
                        err      <= 1'b1;
                        err_code <= ERR_LEFTOVER;
                    end
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_postfix_evaluator.sv
// ---------------------------------------------------------------------------
// tb_postfix_evaluator
//
// Purpose:
//   Self-checking bench for postfix_evaluator. A registered BRAM model feeds
//   the token stream. Each run is compared against a stack-machine reference
//   model written with plain integer arithmetic. The compared items are the
//   result, the error outputs, the done latency and the sequence of read
//   addresses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_postfix_evaluator;

    localparam logic [8:0] OP_ADD = 9'h020;
    localparam logic [8:0] OP_SUB = 9'h021;
    localparam logic [8:0] OP_MUL = 9'h040;
    localparam logic [8:0] OP_DIV = 9'h041;

    logic        CLK_1MHz;
    logic        RSTN;
    logic        start;
    logic [8:0]  top_addr_posf;
    logic [8:0]  addr_posf_b;
    logic [35:0] do_posf_b;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        err;
    logic [2:0]  err_code;

    logic [35:0] mem [0:511];
    logic [35:0] prog [$];

    int checks;
    int errors;

    postfix_evaluator dut (
        .CLK_1MHz      (CLK_1MHz),
        .RSTN          (RSTN),
        .start         (start),
        .top_addr_posf (top_addr_posf),
        .addr_posf_b   (addr_posf_b),
        .do_posf_b     (do_posf_b),
        .result        (result),
        .done          (done),
        .busy          (busy),
        .err           (err),
        .err_code      (err_code)
    );

    initial begin
        CLK_1MHz = 1'b0;
        forever #5 CLK_1MHz = ~CLK_1MHz;
    end

    // Synchronous-read BRAM: data shows up one cycle after the address.
    always @(posedge CLK_1MHz) begin
        do_posf_b <= mem[addr_posf_b];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [35:0] mkOpnd(input logic [31:0] v);
        return {3'($urandom), 1'b0, v};
    endfunction

    function automatic logic [35:0] mkOper(input logic [8:0] c);
        return {3'($urandom), 1'b1, 23'd0, c};
    endfunction

    function automatic logic [31:0] randVal();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3, 4:    return 32'($urandom_range(0, 40)) - 32'd20;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [8:0] randOp();
        case ($urandom_range(0, 12))
            0, 1, 2: return OP_ADD;
            3, 4, 5: return OP_SUB;
            6, 7, 8: return OP_MUL;
            9, 10, 11: return OP_DIV;
            default: return 9'($urandom);
        endcase
    endfunction

    // Reference model: evaluate the token list as a stack machine.
    // It returns the result, the error code and the number of tokens read.
    task automatic modelEval(input int top, output logic [31:0] res,
                             output logic [2:0] code, output int used);
        int stk [$];
        int a, b, r;
        logic [35:0] tok;
        res  = 32'd0;
        code = 3'd0;
        used = 0;
        for (int i = 1; i <= top; i++) begin
            tok  = prog[i-1];
            used = i;
            if (!tok[32]) begin
                if (stk.size() == 16) begin code = 3'd3; break; end
                stk.push_back(int'(tok[31:0]));
            end else begin
                if (stk.size() < 2) begin code = 3'd2; break; end
                b = stk.pop_back();
                a = stk.pop_back();
                if (tok[8:0] == OP_ADD)      r = a + b;
                else if (tok[8:0] == OP_SUB) r = a - b;
                else if (tok[8:0] == OP_MUL) r = int'(longint'(a) * longint'(b));
                else if (tok[8:0] == OP_DIV) begin
                    if (b == 0) begin code = 3'd1; break; end
                    r = int'(longint'(a) / longint'(b));
                end else begin
                    code = 3'd4;
                    break;
                end
                stk.push_back(r);
            end
        end
        if (code == 3'd0) begin
            if (stk.size() == 1) res = stk[0];
            else code = 3'd5;
        end
    endtask

    // Load prog[] into the BRAM and run one evaluation with the given top.
    // If poke is set, start is pulsed while the block is busy.
    task automatic applyStimulus(input string name, input int top, input bit poke);
        logic [31:0] expRes;
        logic [2:0]  expCode;
        int          expUsed, expLat, expAddr, lat;
        bit          gotDone, seqOk;
        logic [8:0]  trace [$];

        for (int i = 0; i < prog.size(); i++) mem[i+1] = prog[i];
        modelEval(top, expRes, expCode, expUsed);
        if (expCode >= 3'd1 && expCode <= 3'd4) begin
            expLat  = 2 * expUsed + 1;
            expAddr = expUsed;
        end else begin
            expLat  = 2 * top + 2;
            expAddr = (top == 0) ? 1 : top;
        end

        @(negedge CLK_1MHz);
        top_addr_posf = 9'(top);
        start = 1'b1;
        @(posedge CLK_1MHz);
        #1;
        start = 1'b0;
        top_addr_posf = 9'($urandom);
        checkOutput({name, "_busy_start"}, 32'(busy), 32'd1);
        trace.delete();
        trace.push_back(addr_posf_b);

        gotDone = 1'b0;
        lat = 0;
        for (int c = 1; c <= 2 * top + 8; c++) begin
            @(posedge CLK_1MHz);
            #1;
            if (poke && c == 3) begin start = 1'b1; top_addr_posf = 9'd1; end
            if (poke && c == 4) start = 1'b0;
            if (addr_posf_b != trace[$]) trace.push_back(addr_posf_b);
            if (done) begin gotDone = 1'b1; lat = c; break; end
        end
        start = 1'b0;

        checkOutput({name, "_done_seen"}, 32'(gotDone), 32'd1);
        checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({name, "_result"}, result, expRes);
        checkOutput({name, "_err"}, 32'(err), 32'(expCode != 3'd0));
        checkOutput({name, "_err_code"}, 32'(err_code), 32'(expCode));
        checkOutput({name, "_busy_end"}, 32'(busy), 32'd0);
        seqOk = (trace.size() == expAddr);
        for (int i = 0; i < trace.size(); i++) if (trace[i] != 9'(i + 1)) seqOk = 1'b0;
        checkOutput({name, "_addr_seq"}, 32'(seqOk), 32'd1);
        checkOutput({name, "_addr_last"}, 32'(addr_posf_b), 32'(expAddr));
        @(posedge CLK_1MHz);
        #1;
        checkOutput({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic genProg(output int top);
        int kind, len, depth;
        prog.delete();
        kind = $urandom_range(0, 9);
        len  = $urandom_range(1, 30);
        if (kind < 7) begin
            depth = 0;
            for (int i = 0; i < len; i++) begin
                if (depth < 2 || (depth < 16 && $urandom_range(0, 1) == 0)) begin
                    prog.push_back(mkOpnd(randVal()));
                    depth++;
                end else begin
                    prog.push_back(mkOper(randOp()));
                    depth--;
                end
            end
            if (kind < 5) begin
                while (depth > 1) begin
                    prog.push_back(mkOper(randOp()));
                    depth--;
                end
            end
        end else if (kind == 7) begin
            for (int i = 0; i < len + 10; i++) prog.push_back(mkOpnd(randVal()));
        end else begin
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 1) == 0) prog.push_back(mkOpnd(randVal()));
                else prog.push_back(mkOper(randOp()));
            end
        end
        top = prog.size();
    endtask

    initial begin
        int  top;
        bit  sawDone;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 512; i++) mem[i] = 36'd0;
        RSTN = 1'b0;
        start = 1'b0;
        top_addr_posf = 9'd0;

        #12;
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_err_code", 32'(err_code), 32'd0);
        checkOutput("reset_addr", 32'(addr_posf_b), 32'd0);
        @(negedge CLK_1MHz);
        RSTN = 1'b1;

        prog = {mkOpnd(32'd3), mkOpnd(32'd4), mkOper(OP_ADD)};
        applyStimulus("add", 3, 1'b0);
        prog = {mkOpnd(32'd2), mkOpnd(32'd3), mkOpnd(32'd4), mkOper(OP_MUL), mkOper(OP_ADD)};
        applyStimulus("mul_add", 5, 1'b0);
        prog = {mkOpnd(32'd7), mkOpnd(-32'sd2), mkOper(OP_DIV)};
        applyStimulus("div_neg", 3, 1'b0);
        prog = {mkOpnd(32'h8000_0000), mkOpnd(32'hFFFF_FFFF), mkOper(OP_DIV)};
        applyStimulus("div_min", 3, 1'b0);
        prog = {mkOpnd(32'd5), mkOpnd(32'd0), mkOper(OP_DIV)};
        applyStimulus("div0", 3, 1'b0);
        prog = {mkOper(OP_ADD)};
        applyStimulus("underflow", 1, 1'b0);
        prog.delete();
        for (int i = 0; i < 17; i++) prog.push_back(mkOpnd(32'(i)));
        applyStimulus("overflow", 17, 1'b0);
        prog = {mkOpnd(32'd1), mkOpnd(32'd2)};
        applyStimulus("leftover", 2, 1'b0);
        prog.delete();
        applyStimulus("top_zero", 0, 1'b0);
        prog = {mkOpnd(32'd1), mkOpnd(32'd2), mkOper(9'h150)};
        applyStimulus("bad_op", 3, 1'b0);
        prog = {mkOpnd(32'd1), mkOpnd(32'd2), mkOper(OP_ADD), mkOpnd(32'd3), mkOper(OP_MUL)};
        applyStimulus("chain_paren", 5, 1'b1);

        prog.delete();
        prog.push_back(mkOpnd(32'd1));
        for (int i = 0; i < 255; i++) begin
            prog.push_back(mkOpnd(32'd1));
            prog.push_back(mkOper(OP_ADD));
        end
        applyStimulus("top_511", 511, 1'b0);

        // Abort a run with an asynchronous reset while it is in EX.
        prog = {mkOpnd(32'd2), mkOpnd(32'd3), mkOpnd(32'd4), mkOper(OP_MUL), mkOper(OP_ADD)};
        for (int i = 0; i < prog.size(); i++) mem[i+1] = prog[i];
        @(negedge CLK_1MHz);
        top_addr_posf = 9'd5;
        start = 1'b1;
        @(posedge CLK_1MHz);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge CLK_1MHz);
            #1;
        end
        #2;
        RSTN = 1'b0;
        #1;
        checkOutput("abort_result", result, 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_err", 32'(err), 32'd0);
        checkOutput("abort_err_code", 32'(err_code), 32'd0);
        checkOutput("abort_addr", 32'(addr_posf_b), 32'd0);
        sawDone = 1'b0;
        repeat (4) begin
            @(posedge CLK_1MHz);
            #1;
            if (done) sawDone = 1'b1;
        end
        @(negedge CLK_1MHz);
        RSTN = 1'b1;
        repeat (4) begin
            @(posedge CLK_1MHz);
            #1;
            if (done) sawDone = 1'b1;
        end
        checkOutput("abort_no_done", 32'(sawDone), 32'd0);
        applyStimulus("abort_rerun", 5, 1'b0);

        for (int n = 0; n < 60; n++) begin
            genProg(top);
            applyStimulus($sformatf("rand%0d", n), top, ($urandom_range(0, 3) == 0) && (top >= 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
